seg7_display_arbiter: RTL
=========================

# seg7_display_arbiter

Shares the 8-digit seven-segment display between three independent requesters (e.g. capture status, frame counter, menu). It grants the display to one requester at a time with round-robin fairness and a guaranteed minimum hold time. It drives the eight 4-bit digit codes that feed the display multiplexer. It sits between the camera control logic and the display scan/decode stage.

## Interface
- TICK_DIV, 100000: I_CLK cycles per hold tick (≥1); 1 ms at 100 MHz.
- HOLD_TICKS, 500: minimum ownership in ticks (≥1).
- I_CLK  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  3  request per requester; level-sensitive, held while display wanted.
- data0, data1, data2  in  32  digit nibbles of each requester; [3:0]→led1 … [31:28]→led8.
- grant  out  3  one-hot registered grant; all-zero when idle.
- owner  out  2  index of current/last owner (0..2).
- busy  out  1  high while any grant is active.
- led1…led8  out  4 each  digit codes to the display multiplexer.

## Operation
- States: IDLE (no grant), HOLD (grant active, min hold running), FREE (grant active, min hold expired).
- Round-robin search order starts at owner+1 mod 3; owner resets to 2, so requester 0 wins the first contest.
- IDLE: if any req bit is set, grant the first pending requester in RR order → HOLD. Set owner, clear the prescaler and hold counter.
- HOLD: the prescaler counts 0..TICK_DIV-1. On wrap, hold_cnt increments. When hold_cnt reaches HOLD_TICKS → FREE.
- In HOLD or FREE, if req[owner] drops:
  - With another request pending, grant the next pending requester in RR order directly (no idle cycle) → HOLD.
  - Otherwise clear grant → IDLE.
- FREE: if req[owner] is still high and another requester is pending, switch to the next pending requester in RR order → HOLD. If no other requester is pending, stay in FREE indefinitely.
- Requests from non-owners never preempt during HOLD. There is no fixed priority.
- While granted: led outputs register the owner's data every cycle, so a live data change shows 1 cycle later.
- Simultaneous owner release and new request in the same cycle: handled as release with a pending request (direct handover).
- Reset mid-operation: the next cycle is IDLE, grant=0, busy=0, owner=2, all led=4'hF, counters=0.

## Timing
- Request seen at cycle N in IDLE → grant/busy high and led showing that requester's data at N+1.
- Grant at cycle G with req held → FREE entered after exactly HOLD_TICKS·TICK_DIV cycles. The earliest handover grant appears at G + HOLD_TICKS·TICK_DIV + 1.
- Release with no pending requester: req low at cycle N → grant=0, busy=0 at N+1.
- Release with a pending requester: req low at cycle N → new one-hot grant at N+1. grant is never all-zero in between and never has two bits set.
- owner updates in the same cycle as grant. owner holds its last value in IDLE.
- Counter widths: prescaler ≥ clog2(TICK_DIV), hold_cnt ≥ clog2(HOLD_TICKS+1). hold_cnt saturates at HOLD_TICKS.

## Configuration
- SEG7_ARB_BLANK_EN defined: on entering IDLE, all led outputs go to 4'hF in the same cycle grant clears, and stay there until the next grant.
- SEG7_ARB_BLANK_EN undefined: in IDLE, led outputs hold the last owner's final registered data.
- Reset value 4'hF applies in both cases.

## Test plan
(All with TICK_DIV=4, HOLD_TICKS=2, so the hold is 8 cycles.)
- Reset then req=3'b111 at cycle 0 → grant=3'b001, owner=0 at cycle 1. led1..led8 follow data0. Handover to grant=3'b010 at cycle 10.
- req=3'b001 only, data0=32'h87654321 → led8..led1 = 8,7,6,5,4,3,2,1 one cycle after grant. After 8 cycles the grant stays 3'b001 (FREE, no contender).
- Owner 0 in HOLD, req[1] rises at cycle 3 → no switch before cycle 9. Handover at cycle 9 relative to grant.
- Owner 1 drops req while req[2] and req[0] are pending → next cycle grant=3'b100 (RR), no all-zero cycle.
- Sole owner drops req → next cycle grant=0, busy=0. led=8×4'hF with SEG7_ARB_BLANK_EN; last data without it.
- rst asserted while in HOLD with owner=1 → next cycle grant=0, owner=2, led=4'hF. A subsequent req=3'b011 grants requester 0.

Source files
------------

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment display among three requesters,
// with a minimum hold time. Optional macro SEG7_ARB_BLANK_EN blanks the digits while idle.
module seg7_display_arbiter #(
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500
) (
    input  logic        I_CLK,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  grant,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [3:0]  led1,
    output logic [3:0]  led2,
    output logic [3:0]  led3,
    output logic [3:0]  led4,
    output logic [3:0]  led5,
    output logic [3:0]  led6,
    output logic [3:0]  led7,
    output logic [3:0]  led8
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FREE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [1:0]     owner_q, owner_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [31:0]    led_q, led_d;

    logic [1:0]     cand1, cand2, rr_idx;
    logic           own_req, other_req;
    logic [31:0]    sel_data;

    function automatic logic [1:0] rr_inc(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order owner+1, owner+2, then owner itself (only reachable from IDLE).
    always_comb begin
        cand1     = rr_inc(owner_q);
        cand2     = rr_inc(cand1);
        own_req   = req[owner_q];
        other_req = req[cand1] | req[cand2];
        if (req[cand1])      rr_idx = cand1;
        else if (req[cand2]) rr_idx = cand2;
        else                 rr_idx = owner_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        presc_d = presc_q;
        hold_d  = hold_q;
        led_d   = led_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_HOLD;
                    grant_d = 3'b001 << rr_idx;
                    owner_d = rr_idx;
                    presc_d = '0;
                    hold_d  = '0;
                end
            end
            S_HOLD, S_FREE: begin
                if (!own_req || (state_q == S_FREE && other_req)) begin
                    if (other_req) begin
                        state_d = S_HOLD;
                        grant_d = 3'b001 << rr_idx;
                        owner_d = rr_idx;
                        presc_d = '0;
                        hold_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 3'b000;
                    end
                end else if (state_q == S_HOLD) begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        hold_d  = hold_q + 1'b1;
                        if (hold_q == HW'(HOLD_TICKS - 1))
                            state_d = S_FREE;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        endcase

        case (owner_d)
            2'd0:    sel_data = data0;
            2'd1:    sel_data = data1;
            default: sel_data = data2;
        endcase

        // Digits track the incoming owner so a new grant shows its data immediately.
        if (state_d != S_IDLE)
            led_d = sel_data;
`ifdef SEG7_ARB_BLANK_EN
        else
            led_d = 32'hFFFF_FFFF;
`endif
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            owner_q <= 2'd2;
            presc_q <= '0;
            hold_q  <= '0;
            led_q   <= 32'hFFFF_FFFF;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            presc_q <= presc_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = |grant_q;
    assign led1  = led_q[3:0];
    assign led2  = led_q[7:4];
    assign led3  = led_q[11:8];
    assign led4  = led_q[15:12];
    assign led5  = led_q[19:16];
    assign led6  = led_q[23:20];
    assign led7  = led_q[27:24];
    assign led8  = led_q[31:28];
endmodule
